// File: rtl/grid_pkg.sv
// Shared defaults, coordinate-width helper and FSM encoding for the grid max/argmax block.
// No logic of its own: no latency, no backpressure.
package grid_pkg;

    localparam int PIX_W_DEF = 24;
    localparam int GRID_DEF  = 8;

    function automatic int coord_w(input int grid);
        return (grid > 1) ? $clog2(grid) : 1;
    endfunction

    localparam int COORD_W_DEF = coord_w(GRID_DEF);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SCAN   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/row_argmax8.sv
// Combinational pairwise max/argmax tree over one grid row; ties resolve to the higher column.
// Latency: zero (pure combinational); backpressure: none.
module row_argmax8 import grid_pkg::*; #(
    parameter  int PIX_W = PIX_W_DEF,
    parameter  int GRID  = GRID_DEF,
    localparam int CW    = coord_w(GRID)
) (
    input  logic [GRID-1:0][PIX_W-1:0] row_pix,
    output logic [PIX_W-1:0]           row_max,
    output logic [CW-1:0]              row_col
);

    always_comb begin : tree
        logic [PIX_W-1:0] v [GRID];
        logic [CW-1:0]    c [GRID];
        for (int i = 0; i < GRID; i++) begin
            v[i] = row_pix[i];
            c[i] = CW'(i);
        end
        // Slot i+s always carries the higher column range, so >= prefers the higher index.
        for (int s = 1; s < GRID; s = s * 2) begin
            for (int i = 0; i < GRID; i = i + 2 * s) begin
                if (v[i+s] >= v[i]) begin
                    v[i] = v[i+s];
                    c[i] = c[i+s];
                end
            end
        end
        row_max = v[0];
        row_col = c[0];
    end

endmodule

// File: rtl/grid_max_ctrl.sv
// Loads a GRIDxGRID pixel grid, scans one row per cycle, reports max value and its (x,y); optional GRID_MAX_THRESH_EN adds i_thresh/o_hit.
// Latency: result valid GRID edges after the final pixel; backpressure: o_ready only in LOAD, result held until i_res_ready.
module grid_max_ctrl import grid_pkg::*; #(
    parameter  int PIX_W = PIX_W_DEF,
    parameter  int GRID  = GRID_DEF,
    localparam int CW    = coord_w(GRID)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [PIX_W-1:0] i_data,
    output logic             o_ready,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [PIX_W-1:0] o_max,
    output logic [CW-1:0]    o_max_x,
    output logic [CW-1:0]    o_max_y,
    output logic             o_busy
`ifdef GRID_MAX_THRESH_EN
   ,input  logic [PIX_W-1:0] i_thresh,
    output logic             o_hit
`endif
);

    state_t state_q, state_d;

    logic [CW-1:0]    x_q, y_q, row_q;
    logic [PIX_W-1:0] max_q;
    logic [CW-1:0]    max_x_q, max_y_q;

    logic [GRID-1:0][PIX_W-1:0] buffer [GRID];

    logic             xfer, last_pix, last_row, take_row;
    logic [PIX_W-1:0] row_max;
    logic [CW-1:0]    row_col;

    assign xfer     = i_valid && (state_q == ST_LOAD);
    assign last_pix = xfer && (x_q == CW'(GRID-1)) && (y_q == CW'(GRID-1));
    assign last_row = (state_q == ST_SCAN) && (row_q == CW'(GRID-1));

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        o_ready     = 1'b0;
        o_res_valid = 1'b0;
        o_busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                o_ready = 1'b1;
                if (last_pix) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (last_row) state_d = ST_RESULT;
            end
            ST_RESULT: begin
                o_res_valid = 1'b1;
                if (i_res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q   <= '0;
            y_q   <= '0;
            row_q <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                x_q <= '0;
                y_q <= '0;
            end else if (xfer) begin
                if (x_q == CW'(GRID-1)) begin
                    x_q <= '0;
                    y_q <= y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
            if (state_q == ST_SCAN) row_q <= row_q + 1'b1;
            else                    row_q <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (xfer) buffer[y_q][x_q] <= i_data;
    end

    row_argmax8 #(
        .PIX_W (PIX_W),
        .GRID  (GRID)
    ) u_row_argmax (
        .row_pix (buffer[row_q]),
        .row_max (row_max),
        .row_col (row_col)
    );

    // Strict compare on later rows keeps the earliest row on a cross-row tie.
    assign take_row = (state_q == ST_SCAN) && ((row_q == '0) || (row_max > max_q));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            max_q   <= '0;
            max_x_q <= '0;
            max_y_q <= '0;
        end else if (take_row) begin
            max_q   <= row_max;
            max_x_q <= row_col;
            max_y_q <= row_q;
        end
    end

    assign o_max   = max_q;
    assign o_max_x = max_x_q;
    assign o_max_y = max_y_q;

`ifdef GRID_MAX_THRESH_EN
    assign o_hit = !i_rst && (state_q == ST_RESULT) && (max_q > i_thresh);
`endif

endmodule

// File: tb/tb_grid_max_ctrl.sv
// Table-driven bench for grid_max_ctrl with an expected-result queue popped on o_res_valid.
module tb_grid_max_ctrl;
    import grid_pkg::*;

    localparam int PW = PIX_W_DEF;
    localparam int G  = GRID_DEF;
    localparam int CW = COORD_W_DEF;
    localparam int NV = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          valid;
    logic [PW-1:0] data;
    logic          ready;
    logic          res_valid;
    logic          res_ready;
    logic [PW-1:0] max_v;
    logic [CW-1:0] max_x;
    logic [CW-1:0] max_y;
    logic          busy;
`ifdef GRID_MAX_THRESH_EN
    logic [PW-1:0] thresh;
    logic          hit;
`endif

    always #5 clk = ~clk;

    grid_max_ctrl #(.PIX_W(PW), .GRID(G)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_valid     (valid),
        .i_data      (data),
        .o_ready     (ready),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_max       (max_v),
        .o_max_x     (max_x),
        .o_max_y     (max_y),
        .o_busy      (busy)
`ifdef GRID_MAX_THRESH_EN
       ,.i_thresh    (thresh),
        .o_hit       (hit)
`endif
    );

    typedef struct {
        int            pat;
        bit            gaps;
        bit            hold;
        logic [PW-1:0] max;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } vec_t;

    typedef struct {
        logic [PW-1:0] max;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } exp_t;

    vec_t vec [NV];
    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int pat, input int idx);
        int x, y;
        x = idx % G;
        y = idx / G;
        case (pat)
            0: return PW'(idx);
            1: return 24'h101010;
            2: return (x == 2 && y == 5) ? 24'hFFFFFF : (x == 6 && y == 1) ? 24'hFFFFFE : 24'h0;
            3: return PW'(G * G - 1 - idx);
            4: return (x == 3 && y == 4) ? 24'h800000 : 24'h7FFFFF;
            5: return ((y == 2 && (x == 1 || x == 6)) || (y == 5 && x == 0)) ? 24'h000055 : 24'h000010;
            default: return 24'hABCDEF;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ready"},     32'(ready),     32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_max"},       32'(max_v),     32'd0);
        chk({tag, "_max_x"},     32'(max_x),     32'd0);
        chk({tag, "_max_y"},     32'(max_y),     32'd0);
    endtask

    task automatic load_grid(input int pat, input bit gaps, input int npix);
        int idx   = 0;
        int guard = 0;
        bit v, rdy;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_in_load", 32'(ready), 32'd1);
        while (idx < npix && guard < 2000) begin
            v     = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            valid = v;
            data  = pix(pat, idx);
            rdy   = ready;
            @(posedge clk); #1;
            guard++;
            if (v && rdy) idx++;
        end
        valid = 1'b0;
        chk("load_count", 32'(idx), 32'(npix));
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;

        vec[0] = '{0, 1'b0, 1'b0, 24'd63,     3'd7, 3'd7};
        vec[1] = '{1, 1'b0, 1'b0, 24'h101010, 3'd7, 3'd0};
        vec[2] = '{2, 1'b0, 1'b0, 24'hFFFFFF, 3'd2, 3'd5};
        vec[3] = '{3, 1'b1, 1'b0, 24'd63,     3'd0, 3'd0};
        vec[4] = '{4, 1'b0, 1'b0, 24'h800000, 3'd3, 3'd4};
        vec[5] = '{5, 1'b1, 1'b0, 24'h000055, 3'd6, 3'd2};
        vec[6] = '{0, 1'b1, 1'b1, 24'd63,     3'd7, 3'd7};

        rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0; res_ready = 1'b0;
`ifdef GRID_MAX_THRESH_EN
        thresh = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            load_grid(vec[k].pat, vec[k].gaps, G * G);
            e.max = vec[k].max; e.x = vec[k].x; e.y = vec[k].y;
            sb.push_back(e);
            wait_result(n);
            chk("latency",   32'(n),         32'(G));
            chk("res_valid", 32'(res_valid), 32'd1);
            e = sb.pop_front();
            chk("max",   32'(max_v), 32'(e.max));
            chk("max_x", 32'(max_x), 32'(e.x));
            chk("max_y", 32'(max_y), 32'(e.y));
            if (vec[k].hold) begin
                for (int j = 0; j < 20; j++) begin
                    start = (j == 5);
                    @(posedge clk); #1;
                    chk("hold_valid", 32'(res_valid), 32'd1);
                    chk("hold_ready", 32'(ready),     32'd0);
                    chk("hold_max",   32'(max_v),     32'(e.max));
                    chk("hold_x",     32'(max_x),     32'(e.x));
                    chk("hold_y",     32'(max_y),     32'(e.y));
                end
                start = 1'b0;
`ifdef GRID_MAX_THRESH_EN
                thresh = 24'd62; #1;
                chk("hit_62", 32'(hit), 32'd1);
                thresh = 24'd63; #1;
                chk("hit_63", 32'(hit), 32'd0);
`endif
            end
            res_ready = 1'b1;
            start     = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            start     = 1'b0;
            chk("idle_after_busy",  32'(busy),      32'd0);
            chk("idle_after_valid", 32'(res_valid), 32'd0);
            @(posedge clk); #1;
            chk("start_ignored", 32'(busy), 32'd0);
        end

        // Partial grid of 30 pixels abandoned by reset, then a fresh grid.
        load_grid(7, 1'b0, 30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("mid_load_rst");
        load_grid(3, 1'b0, G * G);
        e.max = 24'd63; e.x = 3'd0; e.y = 3'd0;
        sb.push_back(e);
        wait_result(n);
        chk("rst_latency", 32'(n), 32'(G));
        e = sb.pop_front();
        chk("rst_max",   32'(max_v), 32'(e.max));
        chk("rst_max_x", 32'(max_x), 32'(e.x));
        chk("rst_max_y", 32'(max_y), 32'(e.y));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Reset in the middle of a scan must drop the pending result.
        load_grid(2, 1'b0, G * G);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("mid_scan_rst");
        repeat (G + 2) @(posedge clk);
        #1;
        chk("no_result_after_rst", 32'(res_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grid_max_ctrl.md
GRID_MAX_CTRL -- requirements
Module: grid_max_ctrl

Interface
REQ-001 SHALL have parameter PIX_W, default 24, pixel width in bits (RGB888 packed).
REQ-002 SHALL have parameter GRID, default 8, grid side in pixels; power of two, 2..16.
REQ-003 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_start  in  1  single-cycle request to begin a grid load.
REQ-006 SHALL have port i_valid  in  1  pixel-stream valid.
REQ-007 SHALL have port i_data  in  PIX_W  pixel; row-major order, x fastest.
REQ-008 SHALL have port o_ready  out  1  pixel-stream ready.
REQ-009 SHALL have port o_res_valid  out  1  result valid.
REQ-010 SHALL have port i_res_ready  in  1  result consumer ready.
REQ-011 SHALL have port o_max  out  PIX_W  maximum pixel value of the grid.
REQ-012 SHALL have port o_max_x  out  log2(GRID)  column of the maximum.
REQ-013 SHALL have port o_max_y  out  log2(GRID)  row of the maximum.
REQ-014 SHALL have port o_busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SCAN, RESULT.
REQ-016 IDLE->LOAD on i_start=1; i_start SHALL be ignored in every other state.
REQ-017 o_ready SHALL be 1 only in LOAD; a pixel transfers on i_valid&o_ready.
REQ-018 Each transfer SHALL write buffer[y][x] and advance x; x wraps GRID-1->0 with y incrementing.
REQ-019 The transfer of pixel GRID*GRID-1 SHALL move LOAD->SCAN with row counter cleared.
REQ-020 SCAN SHALL process one row per cycle: combinational pairwise max tree over the row gives row max and column.
REQ-021 Row-0 scan cycle SHALL load the running max unconditionally; later rows SHALL replace it only when strictly greater.
REQ-022 Within a row, a pairwise tie SHALL select the higher column index; across rows, the lower row SHALL win ties.
REQ-023 Comparison SHALL be unsigned over all PIX_W bits.
REQ-024 The last SCAN cycle SHALL move to RESULT; o_res_valid SHALL be high exactly GRID edges after the edge accepting the final pixel.
REQ-025 In RESULT, o_res_valid=1 and o_max/o_max_x/o_max_y SHALL hold stable until i_res_ready=1, then ->IDLE.
REQ-026 i_start coincident with the result handshake SHALL be ignored; a new load requires i_start in IDLE.
REQ-027 Gaps in i_valid SHALL stall LOAD without losing or reordering pixels.

Reset
REQ-028 i_rst=1 SHALL force IDLE, clear x/y/row counters and running max, and drive o_ready=0, o_res_valid=0, o_busy=0, o_max=0, o_max_x=0, o_max_y=0.
REQ-029 Reset SHALL take precedence over all other inputs, including mid-LOAD or mid-SCAN; partial grids are discarded.
REQ-030 Buffer contents SHALL NOT require reset.

Configuration
REQ-031 Macro GRID_MAX_THRESH_EN: when defined, ports i_thresh (in, PIX_W) and o_hit (out, 1) SHALL exist; o_hit=(o_max>i_thresh) while o_res_valid, else 0, and 0 in reset.
REQ-032 When GRID_MAX_THRESH_EN is undefined, i_thresh and o_hit SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Package grid_pkg SHALL hold PIX_W/GRID defaults, derived coordinate width, and the FSM state enum.
REQ-034 Sub-module row_argmax8 (combinational GRID-input max/argmax tree, tie rule of REQ-022) SHALL be instantiated once in grid_max_ctrl.

Verification
REQ-035 Ramp pixels 0..63, i_valid continuous -> o_max=63, x=7, y=7; o_res_valid high 8 edges after last accept.
REQ-036 All pixels 0x101010 -> o_max=0x101010, x=7, y=0.
REQ-037 Zeros with 0xFFFFFF at (x=2,y=5) and 0xFFFFFE at (6,1) -> o_max=0xFFFFFF, x=2, y=5.
REQ-038 Random i_valid gaps plus i_res_ready low 20 cycles -> same result, outputs stable while held, i_start during RESULT ignored.
REQ-039 i_rst after 30 pixels, then full new grid -> result reflects only new grid; all outputs 0 the cycle after reset.
REQ-040 With GRID_MAX_THRESH_EN, i_thresh=62 on ramp grid -> o_hit=1; i_thresh=63 -> o_hit=0.
